// File: rtl/snake_pkg.sv
// Shared game types for the snake blocks: status codes, directions and body geometry.
package snake_pkg;

    typedef enum logic [1:0] {
        RESTART = 2'b00,
        START   = 2'b01,
        PLAY    = 2'b10,
        DIE     = 2'b11
    } game_status_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam int COORD_W = 6;
    localparam int MAX_LEN = 16;

    function automatic dir_t reverse(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Movement tick divider: counts enabled cycles and pulses o_step on the last count of each period.
module snake_step_timer #(
    parameter int MOVE_DIV = 12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_step
);

    localparam int                CNT_W = $clog2(MOVE_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        o_step = i_en && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_step ? '0 : cnt_q + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/snake_body_unit.sv
// Per-player snake body engine: steps the body on a divided tick, applies key turns and growth,
// and raises sticky wall / self-collision flags for the game controller.
module snake_body_unit
    import snake_pkg::*;
#(
    parameter int         GRID_W   = 40,
    parameter int         GRID_H   = 30,
    parameter int         INIT_X   = 10,
    parameter int         INIT_Y   = 5,
    parameter logic [1:0] INIT_DIR = 2'd3,
    parameter int         MOVE_DIV = 12_500_000
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [1:0]                      i_game_status,
    input  logic [3:0]                      i_key,
    input  logic                            i_grow,
    output logic [MAX_LEN-1:0][COORD_W-1:0] o_cube_x,
    output logic [MAX_LEN-1:0][COORD_W-1:0] o_cube_y,
    output logic [MAX_LEN-1:0]              o_is_exist,
    output logic                            o_hit_wall,
    output logic                            o_hit_body
);

    typedef logic [MAX_LEN-1:0][COORD_W-1:0] coord_arr_t;

    // Head at INIT, two trailing segments laid out opposite to the initial heading.
    function automatic coord_arr_t init_coords(input bit is_x);
        coord_arr_t c;
        int         base;
        int         trail;
        c     = '0;
        base  = is_x ? INIT_X : INIT_Y;
        trail = 0;
        case (dir_t'(INIT_DIR))
            UP:      if (!is_x) trail = 1;
            DOWN:    if (!is_x) trail = -1;
            LEFT:    if (is_x)  trail = 1;
            default: if (is_x)  trail = -1;
        endcase
        for (int k = 0; k < 3; k++) c[k] = COORD_W'(base + k * trail);
        return c;
    endfunction

    localparam coord_arr_t          INIT_CX    = init_coords(1'b1);
    localparam coord_arr_t          INIT_CY    = init_coords(1'b0);
    localparam logic [MAX_LEN-1:0]  INIT_EXIST = MAX_LEN'(7);
    localparam logic [COORD_W-1:0]  X_MAX      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0]  Y_MAX      = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0]  ONE        = COORD_W'(1);

    coord_arr_t          cube_x_q, cube_x_d, cube_y_q, cube_y_d;
    logic [MAX_LEN-1:0]  exist_q, exist_d;
    dir_t                dir_cur_q, dir_cur_d, dir_req_q, dir_req_d;
    logic                grow_pend_q, grow_pend_d;
    logic                hit_wall_q, hit_wall_d, hit_body_q, hit_body_d;

    game_status_t        status;
    logic                step, at_wall, moved, body_hit, key_vld;
    logic [COORD_W-1:0]  new_x, new_y;
    coord_arr_t          shift_x, shift_y;
    logic [MAX_LEN-1:0]  exist_shift;
    dir_t                key_dir, dir_base;

    assign status = game_status_t'(i_game_status);

    snake_step_timer #(
        .MOVE_DIV (MOVE_DIV)
    ) u_step_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (status == PLAY),
        .i_clr   (status == RESTART),
        .o_step  (step)
    );

    // Wall test comes before the add/subtract so an off-grid coordinate is never formed.
    always_comb begin
        new_x   = cube_x_q[0];
        new_y   = cube_y_q[0];
        at_wall = 1'b0;
        case (dir_req_q)
            UP:      if (cube_y_q[0] == '0)    at_wall = 1'b1; else new_y = cube_y_q[0] - ONE;
            DOWN:    if (cube_y_q[0] == Y_MAX) at_wall = 1'b1; else new_y = cube_y_q[0] + ONE;
            LEFT:    if (cube_x_q[0] == '0)    at_wall = 1'b1; else new_x = cube_x_q[0] - ONE;
            default: if (cube_x_q[0] == X_MAX) at_wall = 1'b1; else new_x = cube_x_q[0] + ONE;
        endcase

        moved       = step && !at_wall;
        exist_shift = (moved && grow_pend_q) ? {exist_q[MAX_LEN-2:0], 1'b1} : exist_q;
        shift_x     = {cube_x_q[MAX_LEN-2:0], new_x};
        shift_y     = {cube_y_q[MAX_LEN-2:0], new_y};

        body_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (exist_shift[i] && (shift_x[i] == new_x) && (shift_y[i] == new_y)) body_hit = 1'b1;
        end

        key_vld = 1'b1;
        key_dir = UP;
        if      (i_key[0]) key_dir = UP;
        else if (i_key[1]) key_dir = DOWN;
        else if (i_key[2]) key_dir = LEFT;
        else if (i_key[3]) key_dir = RIGHT;
        else               key_vld = 1'b0;

        // A key arriving on a step cycle is judged against the heading the step commits.
        dir_base = step ? dir_req_q : dir_cur_q;
    end

    always_comb begin
        cube_x_d    = cube_x_q;
        cube_y_d    = cube_y_q;
        exist_d     = exist_q;
        dir_cur_d   = dir_cur_q;
        dir_req_d   = dir_req_q;
        grow_pend_d = grow_pend_q;
        hit_wall_d  = hit_wall_q;
        hit_body_d  = hit_body_q;
        case (status)
            RESTART: begin
                cube_x_d    = INIT_CX;
                cube_y_d    = INIT_CY;
                exist_d     = INIT_EXIST;
                dir_cur_d   = dir_t'(INIT_DIR);
                dir_req_d   = dir_t'(INIT_DIR);
                grow_pend_d = 1'b0;
                hit_wall_d  = 1'b0;
                hit_body_d  = 1'b0;
            end
            PLAY: begin
                if (step) begin
                    dir_cur_d = dir_req_q;
                    if (at_wall) begin
                        hit_wall_d = 1'b1;
                    end else begin
                        cube_x_d = shift_x;
                        cube_y_d = shift_y;
                        exist_d  = exist_shift;
                        if (body_hit) hit_body_d = 1'b1;
                    end
                end
                grow_pend_d = (moved ? 1'b0 : grow_pend_q) | i_grow;
                if (key_vld && (key_dir != reverse(dir_base))) dir_req_d = key_dir;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cube_x_q    <= INIT_CX;
            cube_y_q    <= INIT_CY;
            exist_q     <= INIT_EXIST;
            dir_cur_q   <= dir_t'(INIT_DIR);
            dir_req_q   <= dir_t'(INIT_DIR);
            grow_pend_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_body_q  <= 1'b0;
        end else begin
            cube_x_q    <= cube_x_d;
            cube_y_q    <= cube_y_d;
            exist_q     <= exist_d;
            dir_cur_q   <= dir_cur_d;
            dir_req_q   <= dir_req_d;
            grow_pend_q <= grow_pend_d;
            hit_wall_q  <= hit_wall_d;
            hit_body_q  <= hit_body_d;
        end
    end

    assign o_cube_x   = cube_x_q;
    assign o_cube_y   = cube_y_q;
    assign o_is_exist = exist_q;
    assign o_hit_wall = hit_wall_q;
    assign o_hit_body = hit_body_q;

endmodule

// File: tb/tb_snake_body_unit.sv
// Randomized and scenario bench for snake_body_unit against a list-of-cells snake model.
module tb_snake_body_unit;

    localparam int GW  = 40;
    localparam int GH  = 30;
    localparam int DIV = 4;

    localparam logic [1:0] S_RESTART = 2'b00;
    localparam logic [1:0] S_START   = 2'b01;
    localparam logic [1:0] S_PLAY    = 2'b10;
    localparam logic [1:0] S_DIE     = 2'b11;

    localparam logic [3:0] K_NONE  = 4'b0000;
    localparam logic [3:0] K_UP    = 4'b0001;
    localparam logic [3:0] K_DOWN  = 4'b0010;
    localparam logic [3:0] K_LEFT  = 4'b0100;

    logic             clk;
    logic             rst_n;
    logic [1:0]       game_status;
    logic [3:0]       key;
    logic             grow;
    logic [15:0][5:0] cube_x;
    logic [15:0][5:0] cube_y;
    logic [15:0]      is_exist;
    logic             hit_wall;
    logic             hit_body;

    int total = 0;
    int bad   = 0;

    // Reference model: body as a list of cells (front = head), a length, headings as 0..3.
    int bx [16];
    int by [16];
    int m_len, m_cur, m_req, m_tick;
    bit m_pend, m_wall, m_body;
    int DX  [4] = '{0, 0, -1, 1};
    int DY  [4] = '{-1, 1, 0, 0};
    int OPP [4] = '{1, 0, 3, 2};

    snake_body_unit #(
        .GRID_W   (GW),
        .GRID_H   (GH),
        .INIT_X   (10),
        .INIT_Y   (5),
        .INIT_DIR (2'd3),
        .MOVE_DIV (DIV)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_game_status (game_status),
        .i_key         (key),
        .i_grow        (grow),
        .o_cube_x      (cube_x),
        .o_cube_y      (cube_y),
        .o_is_exist    (is_exist),
        .o_hit_wall    (hit_wall),
        .o_hit_body    (hit_body)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            bx[i] = 0;
            by[i] = 0;
        end
        bx[0] = 10; by[0] = 5;
        bx[1] = 9;  by[1] = 5;
        bx[2] = 8;  by[2] = 5;
        m_len  = 3;
        m_cur  = 3;
        m_req  = 3;
        m_tick = 0;
        m_pend = 0;
        m_wall = 0;
        m_body = 0;
    endtask

    task automatic model_edge(input logic [1:0] st, input logic [3:0] k, input logic g);
        int  base, kd, nx, ny;
        bit  stp;
        if (st == S_RESTART) begin
            model_reset();
            return;
        end
        if (st != S_PLAY) return;
        stp    = (m_tick == DIV - 1);
        m_tick = stp ? 0 : m_tick + 1;
        base   = m_cur;
        if (stp) begin
            m_cur = m_req;
            base  = m_cur;
            nx    = bx[0] + DX[m_cur];
            ny    = by[0] + DY[m_cur];
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                m_wall = 1;
            end else begin
                for (int i = 15; i > 0; i--) begin
                    bx[i] = bx[i-1];
                    by[i] = by[i-1];
                end
                bx[0] = nx;
                by[0] = ny;
                if (m_pend) begin
                    if (m_len < 16) m_len++;
                    m_pend = 0;
                end
                for (int i = 1; i < m_len; i++) begin
                    if (bx[i] == nx && by[i] == ny) m_body = 1;
                end
            end
        end
        if (g) m_pend = 1;
        kd = -1;
        for (int i = 0; i < 4; i++) begin
            if (kd < 0 && k[i]) kd = i;
        end
        if (kd >= 0 && kd != OPP[base]) m_req = kd;
    endtask

    task automatic check_all(input string tag);
        logic [95:0] ex, ey;
        logic [15:0] ee;
        for (int i = 0; i < 16; i++) begin
            ex[i*6 +: 6] = 6'(bx[i]);
            ey[i*6 +: 6] = 6'(by[i]);
        end
        ee = 16'((32'h1 << m_len) - 32'h1);
        chk({tag, "_x"},     128'(cube_x),   128'(ex));
        chk({tag, "_y"},     128'(cube_y),   128'(ey));
        chk({tag, "_exist"}, 128'(is_exist), 128'(ee));
        chk({tag, "_wall"},  128'(hit_wall), 128'(m_wall));
        chk({tag, "_body"},  128'(hit_body), 128'(m_body));
    endtask

    task automatic cyc(input logic [1:0] st, input logic [3:0] k, input logic g, input string tag);
        game_status = st;
        key         = k;
        grow        = g;
        @(posedge clk);
        model_edge(st, k, g);
        #1;
        check_all(tag);
    endtask

    task automatic play_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(S_PLAY, K_NONE, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        check_all(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] st;
        logic [3:0] k;
        logic       g;
        int         r;

        rst_n       = 1'b0;
        game_status = S_RESTART;
        key         = K_NONE;
        grow        = 1'b0;
        model_reset();
        #12;
        chk("rst_hx",    128'(cube_x[0]), 128'd10);
        chk("rst_hy",    128'(cube_y[0]), 128'd5);
        chk("rst_s1x",   128'(cube_x[1]), 128'd9);
        chk("rst_s2x",   128'(cube_x[2]), 128'd8);
        chk("rst_s2y",   128'(cube_y[2]), 128'd5);
        chk("rst_exist", 128'(is_exist),  128'h7);
        chk("rst_wall",  128'(hit_wall),  128'd0);
        chk("rst_body",  128'(hit_body),  128'd0);
        check_all("rst");
        rst_n = 1'b1;

        // Three plain steps.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        play_n(12, "p3");
        chk("p3_hx",   128'(cube_x[0]), 128'd13);
        chk("p3_tail", 128'(cube_x[2]), 128'd11);

        // Reverse key ignored, up accepted, then down (reverse of up) ignored.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        cyc(S_PLAY, K_LEFT, 1'b0, "kl");
        cyc(S_PLAY, K_UP, 1'b0, "ku");
        play_n(2, "kw");
        chk("turn_hx", 128'(cube_x[0]), 128'd10);
        chk("turn_hy", 128'(cube_y[0]), 128'd4);
        cyc(S_PLAY, K_DOWN, 1'b0, "kd");
        play_n(3, "kw2");
        chk("turn2_hy", 128'(cube_y[0]), 128'd3);

        // Grow pulse, then a grow that coincides with a step.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        cyc(S_PLAY, K_NONE, 1'b1, "g1");
        play_n(3, "g1w");
        chk("grow_f", 128'(is_exist), 128'hF);
        play_n(3, "g2w");
        cyc(S_PLAY, K_NONE, 1'b1, "g2s");
        chk("grow_late", 128'(is_exist), 128'hF);
        play_n(4, "g3w");
        chk("grow_1f", 128'(is_exist), 128'h1F);

        // Run into the right wall.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        play_n(4 * 29, "wr");
        chk("wall_pre", 128'(hit_wall), 128'd0);
        play_n(4, "wh");
        chk("wall_hit", 128'(hit_wall),  128'd1);
        chk("wall_hx",  128'(cube_x[0]), 128'd39);
        cyc(S_RESTART, K_NONE, 1'b0, "wrs");
        chk("wall_clr", 128'(hit_wall), 128'd0);

        // Length 5, then up/left/down bites the body; DIE freezes.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        cyc(S_PLAY, K_NONE, 1'b1, "b_g1");
        play_n(3, "b_w1");
        cyc(S_PLAY, K_NONE, 1'b1, "b_g2");
        play_n(3, "b_w2");
        cyc(S_PLAY, K_UP, 1'b0, "b_up");
        play_n(3, "b_w3");
        cyc(S_PLAY, K_LEFT, 1'b0, "b_lf");
        play_n(3, "b_w4");
        chk("body_pre", 128'(hit_body), 128'd0);
        cyc(S_PLAY, K_DOWN, 1'b0, "b_dn");
        play_n(3, "b_w5");
        chk("body_hit", 128'(hit_body), 128'd1);
        chk("body_len", 128'(is_exist), 128'h1F);
        for (int i = 0; i < 6; i++) cyc(S_DIE, 4'(i + 1), 1'b1, "die");
        chk("die_hx", 128'(cube_x[0]), 128'd11);
        chk("die_hy", 128'(cube_y[0]), 128'd5);

        // Random phase.
        cyc(S_RESTART, K_NONE, 1'b0, "rs");
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 2) st = S_RESTART;
            else if (r < 5) st = S_START;
            else if (r < 7) st = S_DIE;
            else            st = S_PLAY;
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : K_NONE;
            g = ($urandom_range(0, 7) == 0);
            cyc(st, k, g, "rnd");
            if (n == 1000) do_reset("arst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
